// File: rtl/rob_pkg.sv
// Shared widths, tag encoding and entry layout for the reorder buffer.
// Tag 0 is reserved for "no producer"; entry index i carries tag i+1.
package rob_pkg;

  localparam int TAG_W = 4;
  localparam int REG_W = 5;
  localparam int DEPTH = 2**TAG_W - 1;

  localparam logic [TAG_W-1:0] NO_TAG = '0;

  typedef struct packed {
    logic             busy;
    logic             ready;
    logic             has_rd;
    logic [REG_W-1:0] rd;
    logic             is_branch;
    logic             mispredict;
    logic [31:0]      value;
    logic [31:0]      target;
  } rob_entry_t;

  function automatic logic [TAG_W-1:0] idx_to_tag(input logic [TAG_W-1:0] idx);
    return idx + TAG_W'(1);
  endfunction

  // Returns {ready, value}; a same-cycle CDB broadcast to a busy, not-yet-ready tag is forwarded.
  function automatic logic [32:0] query_lookup(
    input logic [TAG_W-1:0] tag,
    input rob_entry_t       e,
    input logic             cdb_valid,
    input logic [TAG_W-1:0] cdb_tag,
    input logic [31:0]      cdb_value
  );
    logic [32:0] res;
    res = '0;
    if (tag != NO_TAG && e.busy) begin
      if (e.ready) begin
        res = {1'b1, e.value};
      end else if (cdb_valid && cdb_tag == tag) begin
        res = {1'b1, cdb_value};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rob_ptr_wrap.sv
// Circular pointer for the reorder buffer: increments and wraps after LAST,
// with a synchronous clear that takes priority over the increment.
module rob_ptr_wrap #(
  parameter int             W    = 4,
  parameter logic [W-1:0]   LAST = '1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ptr_q <= '0;
    end else if (en_i) begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: tag allocation at issue, CDB capture, program-order commit, flush on mispredict.
// Define ROB_OPERAND_QUERY_EN to enable the combinational operand query ports (otherwise they read 0).
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_W,
  parameter int Q_WIDTH        = TAG_W
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      rdy_in,
  input  logic                      issue_valid,
  input  logic                      issue_has_rd,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
  input  logic                      issue_is_branch,
  output logic                      full,
  output logic [Q_WIDTH-1:0]        alloc_tag,
  input  logic                      cdb_valid,
  input  logic [Q_WIDTH-1:0]        cdb_tag,
  input  logic [31:0]               cdb_value,
  input  logic                      cdb_mispredict,
  input  logic [31:0]               cdb_target_pc,
  output logic                      has_commit,
  output logic [REG_ADDR_WIDTH-1:0] commit_target,
  output logic [Q_WIDTH-1:0]        commit_q,
  output logic [31:0]               commit_v,
  output logic                      flush_out,
  output logic [31:0]               flush_pc,
  input  logic [Q_WIDTH-1:0]        q1_tag,
  input  logic [Q_WIDTH-1:0]        q2_tag,
  output logic                      q1_ready,
  output logic                      q2_ready,
  output logic [31:0]               q1_value,
  output logic [31:0]               q2_value
);

  rob_entry_t entries_q [DEPTH];
  rob_entry_t entries_d [DEPTH];

  logic [TAG_W-1:0] head_q;
  logic [TAG_W-1:0] tail_q;
  logic [TAG_W-1:0] count_q;
  logic [TAG_W-1:0] count_d;

  logic                      has_commit_q,    has_commit_d;
  logic [REG_ADDR_WIDTH-1:0] commit_target_q, commit_target_d;
  logic [Q_WIDTH-1:0]        commit_q_q,      commit_q_d;
  logic [31:0]               commit_v_q,      commit_v_d;
  logic                      flush_q,         flush_d;
  logic [31:0]               flush_pc_q,      flush_pc_d;

  rob_entry_t       head_e;
  logic [TAG_W-1:0] cdb_idx;
  logic             issue_acc;
  logic             commit_fire;
  logic             flush_fire;
  logic             cdb_hit;

  assign head_e      = entries_q[head_q];
  assign full        = (count_q == TAG_W'(DEPTH));
  assign alloc_tag   = idx_to_tag(tail_q);
  assign issue_acc   = issue_valid && !full;
  // Readiness is taken from registered state, so a CDB write to the head commits one cycle later.
  assign commit_fire = head_e.busy && head_e.ready;
  assign flush_fire  = commit_fire && head_e.is_branch && head_e.mispredict;
  assign cdb_idx     = cdb_tag - TAG_W'(1);
  assign cdb_hit     = cdb_valid && (cdb_tag != NO_TAG) && entries_q[cdb_idx].busy;

  rob_ptr_wrap #(.W(TAG_W), .LAST(TAG_W'(DEPTH - 1))) u_head_ptr (
    .clk_i   (clk_in),
    .rst_n_i (rst_n_in),
    .en_i    (rdy_in),
    .clr_i   (flush_fire),
    .inc_i   (commit_fire),
    .ptr_o   (head_q)
  );

  rob_ptr_wrap #(.W(TAG_W), .LAST(TAG_W'(DEPTH - 1))) u_tail_ptr (
    .clk_i   (clk_in),
    .rst_n_i (rst_n_in),
    .en_i    (rdy_in),
    .clr_i   (flush_fire),
    .inc_i   (issue_acc),
    .ptr_o   (tail_q)
  );

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
    end
    if (flush_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i] = '0;
      end
    end else begin
      if (cdb_hit) begin
        entries_d[cdb_idx].ready      = 1'b1;
        entries_d[cdb_idx].value      = cdb_value;
        entries_d[cdb_idx].mispredict = cdb_mispredict;
        entries_d[cdb_idx].target     = cdb_target_pc;
      end
      if (commit_fire) begin
        entries_d[head_q] = '0;
      end
      if (issue_acc) begin
        entries_d[tail_q]           = '0;
        entries_d[tail_q].busy      = 1'b1;
        entries_d[tail_q].has_rd    = issue_has_rd;
        entries_d[tail_q].rd        = issue_rd;
        entries_d[tail_q].is_branch = issue_is_branch;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush_fire) begin
      count_d = '0;
    end else if (issue_acc && !commit_fire) begin
      count_d = count_q + TAG_W'(1);
    end else if (!issue_acc && commit_fire) begin
      count_d = count_q - TAG_W'(1);
    end
  end

  always_comb begin
    has_commit_d    = 1'b0;
    commit_target_d = commit_target_q;
    commit_q_d      = commit_q_q;
    commit_v_d      = commit_v_q;
    flush_d         = 1'b0;
    flush_pc_d      = flush_pc_q;
    if (commit_fire) begin
      has_commit_d    = head_e.has_rd;
      commit_target_d = head_e.rd;
      commit_q_d      = idx_to_tag(head_q);
      commit_v_d      = head_e.value;
    end
    if (flush_fire) begin
      flush_d    = 1'b1;
      flush_pc_d = head_e.target;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      count_q         <= '0;
      has_commit_q    <= 1'b0;
      commit_target_q <= '0;
      commit_q_q      <= '0;
      commit_v_q      <= '0;
      flush_q         <= 1'b0;
      flush_pc_q      <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
      count_q         <= count_d;
      has_commit_q    <= has_commit_d;
      commit_target_q <= commit_target_d;
      commit_q_q      <= commit_q_d;
      commit_v_q      <= commit_v_d;
      flush_q         <= flush_d;
      flush_pc_q      <= flush_pc_d;
    end
  end

  assign has_commit    = has_commit_q;
  assign commit_target = commit_target_q;
  assign commit_q      = commit_q_q;
  assign commit_v      = commit_v_q;
  assign flush_out     = flush_q;
  assign flush_pc      = flush_pc_q;

`ifdef ROB_OPERAND_QUERY_EN
  logic [TAG_W-1:0] q1_idx;
  logic [TAG_W-1:0] q2_idx;
  logic [32:0]      q1_res;
  logic [32:0]      q2_res;

  assign q1_idx   = q1_tag - TAG_W'(1);
  assign q2_idx   = q2_tag - TAG_W'(1);
  assign q1_res   = query_lookup(q1_tag, entries_q[q1_idx], cdb_valid, cdb_tag, cdb_value);
  assign q2_res   = query_lookup(q2_tag, entries_q[q2_idx], cdb_valid, cdb_tag, cdb_value);
  assign q1_ready = q1_res[32];
  assign q1_value = q1_res[31:0];
  assign q2_ready = q2_res[32];
  assign q2_value = q2_res[31:0];
`else
  logic unused_query;

  assign unused_query = ^{q1_tag, q2_tag};
  assign q1_ready     = 1'b0;
  assign q1_value     = '0;
  assign q2_ready     = 1'b0;
  assign q2_value     = '0;
`endif

endmodule
